filter_path_sequencer: RTL and testbench

- Sequences one sample from the ADC packager through the FIR high-pass and low-pass filters to the DAC packager.
- Runs on the DAC serial clock domain.
- On each ADC sync pulse it latches the packaged ADC word and issues one sink-valid strobe to both filters.
- It then collects the two filter outputs, or times out, and selects or mixes them per the mode input. The result is presented as a held DAC word plus a one-cycle valid strobe.

---
 rtl/filter_path_sequencer_if.sv | 36 +++
 rtl/filter_path_sequencer.sv | 146 ++++++++++++++
 tb/tb_filter_path_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/filter_path_sequencer_if.sv
// Signal bundle between the filter path sequencer and its ADC/filter/DAC neighbours.
// The slave modport is the sequencer; the master modport is the surrounding datapath.
interface filter_path_sequencer_if #(
  parameter int DATA_WIDTH  = 12,
  parameter int COUNT_WIDTH = 8
);
  logic                   syncADC;
  logic [DATA_WIDTH-1:0]  adcDataOutPackage;
  logic [1:0]             filterMode;
  logic                   highPassSinkValid;
  logic                   lowPassSinkValid;
  logic [DATA_WIDTH-1:0]  filterSample;
  logic                   highPassOutValid;
  logic [DATA_WIDTH-1:0]  highPassOutput;
  logic                   lowPassOutValid;
  logic [DATA_WIDTH-1:0]  lowPassOutput;
  logic [DATA_WIDTH-1:0]  dacSample;
  logic                   dacSampleValid;
  logic                   busy;
  logic                   timeoutFlag;
  logic [COUNT_WIDTH-1:0] overrunCount;

  modport master (
    output syncADC, adcDataOutPackage, filterMode,
    output highPassOutValid, highPassOutput, lowPassOutValid, lowPassOutput,
    input  highPassSinkValid, lowPassSinkValid, filterSample,
    input  dacSample, dacSampleValid, busy, timeoutFlag, overrunCount
  );

  modport slave (
    input  syncADC, adcDataOutPackage, filterMode,
    input  highPassOutValid, highPassOutput, lowPassOutValid, lowPassOutput,
    output highPassSinkValid, lowPassSinkValid, filterSample,
    output dacSample, dacSampleValid, busy, timeoutFlag, overrunCount
  );
endinterface

// File: rtl/filter_path_sequencer.sv
// Moves one ADC sample through the high/low-pass filters and on to the DAC packager,
// selecting or saturating-summing the filter results according to the latched mode.
module filter_path_sequencer #(
  parameter int DATA_WIDTH  = 12,
  parameter int TIMEOUT     = 64,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                  dacSerialClock,
  input  logic                  reset,
  filter_path_sequencer_if.slave bus
);
  localparam int MSB = DATA_WIDTH - 1;
  localparam int TW  = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_SELECT, S_PRESENT
  } state_t;

  state_t r_state, w_next;

  logic signed [MSB:0]    r_fs, r_hp, r_lp, r_result, w_result;
  logic [MSB:0]           r_dac;
  logic [1:0]             r_mode;
  logic                   r_hp_got, r_lp_got;
  logic [TW-1:0]          r_timer;
  logic                   r_hp_sv, r_lp_sv, r_dac_vld, r_tflag;
  logic [COUNT_WIDTH-1:0] r_ovr;
  logic                   w_hp_got, w_lp_got, w_done, w_tmo, w_exit;

  function automatic logic signed [MSB:0] sat_add(input logic signed [MSB:0] a,
                                                  input logic signed [MSB:0] b);
    logic signed [DATA_WIDTH:0] s;
    s = {a[MSB], a} + {b[MSB], b};
    if (s[DATA_WIDTH] != s[MSB])
      sat_add = s[DATA_WIDTH] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
    else
      sat_add = s[MSB:0];
  endfunction

  // Offset binary and two's complement differ only in the MSB.
  function automatic logic [MSB:0] flip_msb(input logic [MSB:0] v);
    flip_msb = {~v[MSB], v[MSB-1:0]};
  endfunction

  assign w_hp_got = r_hp_got | bus.highPassOutValid;
  assign w_lp_got = r_lp_got | bus.lowPassOutValid;
  assign w_done   = (~r_mode[1] | w_hp_got) & (~r_mode[0] | w_lp_got);
  assign w_tmo    = (r_timer == TMO_LAST);
  assign w_exit   = w_done | w_tmo;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (bus.syncADC) w_next = S_ISSUE;
      S_ISSUE:   w_next = (r_mode == 2'b00) ? S_SELECT : S_WAIT;
      S_WAIT:    if (w_exit) w_next = S_SELECT;
      S_SELECT:  w_next = S_PRESENT;
      S_PRESENT: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_result = r_fs;
    unique case (r_mode)
      2'b00:   w_result = r_fs;
      2'b01:   w_result = r_lp;
      2'b10:   w_result = r_hp;
      default: w_result = sat_add(r_lp, r_hp);
    endcase
  end

  always_ff @(posedge dacSerialClock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge dacSerialClock or posedge reset) begin
    if (reset) begin
      r_fs      <= '0;
      r_hp      <= '0;
      r_lp      <= '0;
      r_result  <= '0;
      r_dac     <= '0;
      r_mode    <= '0;
      r_hp_got  <= 1'b0;
      r_lp_got  <= 1'b0;
      r_timer   <= '0;
      r_hp_sv   <= 1'b0;
      r_lp_sv   <= 1'b0;
      r_dac_vld <= 1'b0;
      r_tflag   <= 1'b0;
      r_ovr     <= '0;
    end else begin
      r_hp_sv   <= 1'b0;
      r_lp_sv   <= 1'b0;
      r_dac_vld <= 1'b0;
      if (bus.syncADC && (r_state != S_IDLE) && (r_ovr != '1))
        r_ovr <= r_ovr + 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (bus.syncADC) begin
            r_fs   <= flip_msb(bus.adcDataOutPackage);
            r_mode <= bus.filterMode;
            // Strobes are registered so they are high during the ISSUE cycle.
            r_hp_sv <= (bus.filterMode != 2'b00);
            r_lp_sv <= (bus.filterMode != 2'b00);
          end
        end
        S_ISSUE: begin
          r_hp_got <= 1'b0;
          r_lp_got <= 1'b0;
          r_timer  <= '0;
        end
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (bus.highPassOutValid) begin
            r_hp     <= bus.highPassOutput;
            r_hp_got <= 1'b1;
          end
          if (bus.lowPassOutValid) begin
            r_lp     <= bus.lowPassOutput;
            r_lp_got <= 1'b1;
          end
          if (w_exit && !w_done) r_tflag <= 1'b1;
        end
        S_SELECT:  r_result <= w_result;
        S_PRESENT: begin
          r_dac     <= flip_msb(r_result);
          r_dac_vld <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.highPassSinkValid = r_hp_sv;
  assign bus.lowPassSinkValid  = r_lp_sv;
  assign bus.filterSample      = r_fs;
  assign bus.dacSample         = r_dac;
  assign bus.dacSampleValid    = r_dac_vld;
  assign bus.busy              = (r_state != S_IDLE);
  assign bus.timeoutFlag       = r_tflag;
  assign bus.overrunCount      = r_ovr;
endmodule

// File: tb/tb_filter_path_sequencer.sv
// Scoreboard bench for filter_path_sequencer: a driver issues samples and filter responses,
// a reference model predicts the DAC word and latency, and a monitor checks each output strobe.
module tb_filter_path_sequencer;
  localparam int W   = 12;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  filter_path_sequencer_if #(.DATA_WIDTH(W), .COUNT_WIDTH(8)) bus ();

  filter_path_sequencer #(.DATA_WIDTH(W), .TIMEOUT(TMO), .COUNT_WIDTH(8)) dut (
    .dacSerialClock(clk),
    .reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] dac;
    int           cyc;
    int           lat;
  } exp_t;
  exp_t q[$];

  // Reference model state: last captured filter words, sticky flag, drop counter.
  logic [W-1:0] m_hp = '0, m_lp = '0;
  bit           m_tflag = 1'b0;
  int           m_ovr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every DAC strobe must match the oldest prediction in value and latency.
  always @(negedge clk) begin
    if (!rst && bus.dacSampleValid) begin
      if (q.size() == 0) begin
        chk("unexpected_dac_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("dacSample", {20'd0, bus.dacSample}, {20'd0, e.dac});
        chk("latency", cyc - e.cyc, e.lat);
      end
    end
  end

  task automatic clear_inputs();
    bus.syncADC = 1'b0;
    bus.highPassOutValid = 1'b0;
    bus.lowPassOutValid = 1'b0;
    bus.highPassOutput = W'($urandom);
    bus.lowPassOutput = W'($urandom);
  endtask

  // One sample. d_hp/d_lp: WAIT-cycle offset of each filter valid (-1 = never).
  // ov_n: number of consecutive WAIT cycles with syncADC held high (all dropped).
  task automatic run_txn(input logic [1:0] mode, input logic [W-1:0] adc,
                         input int d_hp, input int d_lp,
                         input logic [W-1:0] hpv, input logic [W-1:0] lpv, input int ov_n);
    int   e, maxd, n, s;
    bit   tmo;
    logic [W-1:0] r;
    exp_t x;
    tmo = 1'b0;
    e = -1;
    if (mode != 2'b00) begin
      e = 0;
      if (mode[1]) begin
        if (d_hp < 0 || d_hp > TMO - 1) tmo = 1'b1;
        else if (d_hp > e) e = d_hp;
      end
      if (mode[0]) begin
        if (d_lp < 0 || d_lp > TMO - 1) tmo = 1'b1;
        else if (d_lp > e) e = d_lp;
      end
      if (tmo) e = TMO - 1;
      if (d_hp >= 0 && d_hp <= e) m_hp = hpv;
      if (d_lp >= 0 && d_lp <= e) m_lp = lpv;
      if (tmo) m_tflag = 1'b1;
      if (ov_n > e + 1) ov_n = e + 1;
    end else begin
      ov_n = 0;
    end
    m_ovr = (m_ovr + ov_n > 255) ? 255 : m_ovr + ov_n;

    case (mode)
      2'b00: r = adc ^ 12'h800;
      2'b01: r = m_lp;
      2'b10: r = m_hp;
      default: begin
        s = $signed(m_lp) + $signed(m_hp);
        if (s > 2047) s = 2047;
        if (s < -2048) s = -2048;
        r = s[W-1:0];
      end
    endcase

    @(negedge clk);
    bus.syncADC = 1'b1;
    bus.adcDataOutPackage = adc;
    bus.filterMode = mode;
    x.dac = r ^ 12'h800;
    x.cyc = cyc;
    x.lat = (mode == 2'b00) ? 4 : 5 + e;
    q.push_back(x);

    @(negedge clk);
    bus.syncADC = 1'b0;
    bus.filterMode = 2'($urandom);
    chk("hpSinkValid", {31'd0, bus.highPassSinkValid}, {31'd0, mode != 2'b00});
    chk("lpSinkValid", {31'd0, bus.lowPassSinkValid}, {31'd0, mode != 2'b00});
    chk("filterSample", {20'd0, bus.filterSample}, {20'd0, adc ^ 12'h800});
    chk("busy_issue", {31'd0, bus.busy}, 32'd1);

    if (mode != 2'b00) begin
      maxd = d_hp;
      if (d_lp > maxd) maxd = d_lp;
      if (ov_n - 1 > maxd) maxd = ov_n - 1;
      for (int k = 0; k <= maxd; k++) begin
        @(negedge clk);
        bus.highPassOutValid = (k == d_hp);
        bus.highPassOutput = (k == d_hp) ? hpv : W'($urandom);
        bus.lowPassOutValid = (k == d_lp);
        bus.lowPassOutput = (k == d_lp) ? lpv : W'($urandom);
        bus.syncADC = (k < ov_n);
      end
      @(negedge clk);
      clear_inputs();
    end

    n = 0;
    while (bus.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("busy_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
    chk("timeoutFlag", {31'd0, bus.timeoutFlag}, {31'd0, m_tflag});
    chk("overrunCount", {24'd0, bus.overrunCount}, m_ovr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dh, dl;
    clear_inputs();
    bus.adcDataOutPackage = '0;
    bus.filterMode = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_dacSample", {20'd0, bus.dacSample}, 32'd0);
    chk("rst_dacSampleValid", {31'd0, bus.dacSampleValid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_filterSample", {20'd0, bus.filterSample}, 32'd0);
    chk("rst_overrun", {24'd0, bus.overrunCount}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_txn(2'b00, 12'hA00, -1, -1, 12'h000, 12'h000, 0);
    run_txn(2'b01, 12'h123, -1, 4, 12'h000, 12'hF00, 0);
    run_txn(2'b11, 12'h456, 2, 2, 12'h600, 12'h500, 0);
    run_txn(2'b11, 12'h789, 1, 1, 12'h900, 12'h900, 0);
    run_txn(2'b11, 12'h0AB, -1, 3, 12'h000, 12'h100, 0);
    run_txn(2'b10, 12'h0CD, 6, -1, 12'h3C0, 12'h000, 0);

    for (int i = 0; i < 30; i++) begin
      dh = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 20);
      dl = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 20);
      if ($urandom_range(0, 15) == 0) dl = 70;
      run_txn(2'($urandom), W'($urandom), dh, dl, W'($urandom), W'($urandom),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0);
    end

    for (int i = 0; i < 5; i++)
      run_txn(2'b01, W'($urandom), -1, TMO - 1, 12'h000, W'($urandom), TMO);

    // Abandon a sample mid-WAIT with an asynchronous reset.
    @(negedge clk);
    bus.syncADC = 1'b1;
    bus.filterMode = 2'b01;
    bus.adcDataOutPackage = 12'h5A5;
    @(negedge clk);
    bus.syncADC = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_dacSample", {20'd0, bus.dacSample}, 32'd0);
    chk("arst_dacSampleValid", {31'd0, bus.dacSampleValid}, 32'd0);
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_timeoutFlag", {31'd0, bus.timeoutFlag}, 32'd0);
    chk("arst_overrun", {24'd0, bus.overrunCount}, 32'd0);
    chk("arst_filterSample", {20'd0, bus.filterSample}, 32'd0);
    chk("arst_sinkValid", {30'd0, bus.highPassSinkValid, bus.lowPassSinkValid}, 32'd0);
    m_hp = '0;
    m_lp = '0;
    m_tflag = 1'b0;
    m_ovr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_txn(2'b11, 12'h321, -1, 2, 12'h000, 12'h2F0, 0);
    run_txn(2'b01, 12'h654, 3, 5, 12'h111, 12'h7FF, 0);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
